// File: rtl/dm_wt_cache_if.sv
// CPU request/response and RAM bus bundle for dm_wt_cache.
// The slave modport is the cache. The master modport is the surrounding CPU and RAM environment.
interface dm_wt_cache_if #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 16
);
    logic                  req_valid;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  req_ready;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_hit;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic                  ram_cs;
    logic                  ram_we;
    logic                  ram_oe;
    logic [DATA_WIDTH-1:0] ram_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, ram_rdata,
        output req_ready, resp_valid, resp_rdata, resp_hit,
               ram_addr, ram_wdata, ram_cs, ram_we, ram_oe
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, ram_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_hit,
               ram_addr, ram_wdata, ram_cs, ram_we, ram_oe
    );
endinterface

// File: rtl/dm_wt_cache.sv
// Direct-mapped, write-through, write-allocate cache with one word per line.
// It also provides a single-cycle flush and saturating hit/miss counters.
module dm_wt_cache #(
    parameter int ADDR_WIDTH  = 14,
    parameter int DATA_WIDTH  = 16,
    parameter int INDEX_WIDTH = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    dm_wt_cache_if.slave         bus,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);
    localparam int LINES     = 1 << INDEX_WIDTH;
    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    logic [2:0]            state_q, state_d;
    logic                  we_q, we_d;
    logic                  hit_q, hit_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [CNT_WIDTH-1:0]  hit_cnt_q, hit_cnt_d;
    logic [CNT_WIDTH-1:0]  miss_cnt_q, miss_cnt_d;
    logic [LINES-1:0]      valid_q, valid_d;

    // Tag and data arrays are read combinationally so the lookup completes in IDLE.
    logic [DATA_WIDTH-1:0] data_mem [LINES];
    logic [TAG_WIDTH-1:0]  tag_mem  [LINES];

    logic [INDEX_WIDTH-1:0] req_idx, idx_q;
    logic [TAG_WIDTH-1:0]   req_tag, tag_q;
    logic                   lookup_hit;
    logic                   accept;
    logic                   line_we;
    logic [DATA_WIDTH-1:0]  line_wdata;
    logic                   flush_now;

    assign req_idx    = bus.req_addr[INDEX_WIDTH-1:0];
    assign req_tag    = bus.req_addr[ADDR_WIDTH-1:INDEX_WIDTH];
    assign idx_q      = addr_q[INDEX_WIDTH-1:0];
    assign tag_q      = addr_q[ADDR_WIDTH-1:INDEX_WIDTH];
    assign lookup_hit = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

    assign bus.req_ready = !rst && (state_q == S_IDLE) && !flush;
    assign accept        = bus.req_valid && bus.req_ready;
    assign flush_now     = (state_q == S_IDLE) && flush;

    // Fill and write both allocate; reset suppresses the update so an aborted fill leaves no trace.
    assign line_we    = !rst && ((state_q == S_WAIT) || (state_q == S_WRITE));
    assign line_wdata = (state_q == S_WAIT) ? bus.ram_rdata : wdata_q;

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        hit_d      = hit_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    we_d    = bus.req_we;
                    hit_d   = lookup_hit;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    if (bus.req_we) begin
                        state_d = S_WRITE;
                        rdata_d = bus.req_wdata;
                    end else if (lookup_hit) begin
                        state_d = S_RESP;
                        rdata_d = data_mem[req_idx];
                    end else begin
                        state_d = S_FILL;
                    end
                    if (lookup_hit) begin
                        if (hit_cnt_q != {CNT_WIDTH{1'b1}})
                            hit_cnt_d = hit_cnt_q + CNT_WIDTH'(1);
                    end else begin
                        if (miss_cnt_q != {CNT_WIDTH{1'b1}})
                            miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            S_FILL:  state_d = S_WAIT;
            S_WAIT: begin
                state_d = S_RESP;
                rdata_d = bus.ram_rdata;
            end
            S_WRITE: state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : g_valid
            assign valid_d[gi] = flush_now ? 1'b0 :
                                 (line_we && (idx_q == INDEX_WIDTH'(gi))) ? 1'b1 :
                                 valid_q[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            we_q       <= 1'b0;
            hit_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            hit_q      <= hit_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            valid_q    <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (line_we) begin
            data_mem[idx_q] <= line_wdata;
            tag_mem[idx_q]  <= tag_q;
        end
    end

    assign bus.resp_valid = (state_q == S_RESP);
    assign bus.resp_hit   = (state_q == S_RESP) && hit_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.ram_cs     = (state_q == S_FILL) || (state_q == S_WRITE);
    assign bus.ram_we     = (state_q == S_WRITE);
    assign bus.ram_oe     = (state_q == S_FILL);
    assign bus.ram_addr   = addr_q;
    assign bus.ram_wdata  = wdata_q;
    assign hit_count      = hit_cnt_q;
    assign miss_count     = miss_cnt_q;

    // The latched write-enable is kept only for debug visibility of the in-flight access.
    logic unused_we;
    assign unused_we = we_q;
endmodule

// File: tb/tb_dm_wt_cache.sv
// Directed bench for dm_wt_cache: miss/hit/write latencies, conflicts, flush, saturation and mid-fill reset.
module tb_dm_wt_cache;
    localparam int AW = 14;
    localparam int DW = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic [1:0] hit_count, miss_count;
    int         tests = 0;
    int         fails = 0;

    dm_wt_cache_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    dm_wt_cache #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INDEX_WIDTH(4), .CNT_WIDTH(2)) dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // Word RAM with registered read data.
    logic [DW-1:0] ram_mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.ram_cs && bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
        if (bus.ram_cs && bus.ram_oe) bus.ram_rdata <= ram_mem[bus.ram_addr];
    end

    logic          cs_at [0:7];
    logic          we_at [0:7];
    logic          oe_at [0:7];
    logic [AW-1:0] addr_at [0:7];
    logic [DW-1:0] wdata_at [0:7];

    task automatic apply_reset();
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Issues one request and records the cycles after acceptance until resp_valid.
    task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input logic with_flush, output int rcyc, output logic [DW-1:0] rd,
                         output logic hit, output logic ready_first);
        int n;
        rcyc = -1; rd = '0; hit = 1'b0; ready_first = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cs_at[k] = 0; we_at[k] = 0; oe_at[k] = 0; addr_at[k] = '0; wdata_at[k] = '0;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr; bus.req_wdata = wd;
        flush = with_flush;
        if (with_flush) begin
            @(negedge clk); ready_first = bus.req_ready;
            @(posedge clk); #1 flush = 1'b0;
        end
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
        if (!bus.req_ready) begin
            tests++; fails++;
            $display("FAIL accept_timeout: req_ready stayed %b, required 1", bus.req_ready);
            bus.req_valid = 1'b0;
            return;
        end
        cs_at[0] = bus.ram_cs;
        @(posedge clk); #1 bus.req_valid = 1'b0;
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            cs_at[k] = bus.ram_cs; we_at[k] = bus.ram_we; oe_at[k] = bus.ram_oe;
            addr_at[k] = bus.ram_addr; wdata_at[k] = bus.ram_wdata;
            if (bus.resp_valid) begin
                rcyc = k; rd = bus.resp_rdata; hit = bus.resp_hit;
                break;
            end
        end
        $display("[TB] txn we=%0d addr=%h wdata=%h -> resp_cycle=%0d rdata=%h hit=%0d hits=%0d misses=%0d",
                 we, addr, wd, rcyc, rd, hit, hit_count, miss_count);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++; if (bus.req_ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b required 0", bus.req_ready); end
        tests++; if ({bus.resp_valid, bus.resp_hit} !== 2'b00) begin fails++; $display("FAIL rst_resp: got %b required 00", {bus.resp_valid, bus.resp_hit}); end
        tests++; if (bus.resp_rdata !== 16'h0000) begin fails++; $display("FAIL rst_rdata: got %h required 0000", bus.resp_rdata); end
        tests++; if ({bus.ram_cs, bus.ram_we, bus.ram_oe} !== 3'b000) begin fails++; $display("FAIL rst_strobes: got %b required 000", {bus.ram_cs, bus.ram_we, bus.ram_oe}); end
        tests++; if ({bus.ram_addr, bus.ram_wdata} !== 30'h0) begin fails++; $display("FAIL rst_ram_bus: got %h/%h required 0/0", bus.ram_addr, bus.ram_wdata); end
        tests++; if ({hit_count, miss_count} !== 4'h0) begin fails++; $display("FAIL rst_counts: got %0d/%0d required 0/0", hit_count, miss_count); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        tests++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready: got %b required 1", bus.req_ready); end
        tests++; if (bus.resp_valid !== 1'b0) begin fails++; $display("FAIL rst_release_resp: got %b required 0", bus.resp_valid); end
    endtask

    task automatic test_read_miss_hit();
        int rc; logic [DW-1:0] rd; logic h, rf;
        issue(1'b0, 14'h120, 16'h0, 1'b0, rc, rd, h, rf);
        tests++; if (rc !== 3) begin fails++; $display("FAIL miss_latency: got %0d required 3", rc); end
        tests++; if ({cs_at[1], oe_at[1], we_at[1]} !== 3'b110) begin fails++; $display("FAIL fill_strobes: got %b required 110", {cs_at[1], oe_at[1], we_at[1]}); end
        tests++; if (addr_at[1] !== 14'h120) begin fails++; $display("FAIL fill_addr: got %h required 0120", addr_at[1]); end
        tests++; if (cs_at[2] !== 1'b0) begin fails++; $display("FAIL wait_cs: got %b required 0", cs_at[2]); end
        tests++; if ({rd, h} !== {16'h0001, 1'b0}) begin fails++; $display("FAIL miss_resp: got %h hit=%b required 0001 hit=0", rd, h); end
        tests++; if (miss_count !== 2'd1) begin fails++; $display("FAIL miss_count1: got %0d required 1", miss_count); end
        issue(1'b0, 14'h120, 16'h0, 1'b0, rc, rd, h, rf);
        tests++; if (rc !== 1) begin fails++; $display("FAIL hit_latency: got %0d required 1", rc); end
        tests++; if ({rd, h} !== {16'h0001, 1'b1}) begin fails++; $display("FAIL hit_resp: got %h hit=%b required 0001 hit=1", rd, h); end
        tests++; if ({cs_at[0], cs_at[1]} !== 2'b00) begin fails++; $display("FAIL hit_no_ram: got %b required 00", {cs_at[0], cs_at[1]}); end
        tests++; if (hit_count !== 2'd1) begin fails++; $display("FAIL hit_count1: got %0d required 1", hit_count); end
    endtask

    task automatic test_write();
        int rc; logic [DW-1:0] rd; logic h, rf;
        issue(1'b1, 14'h11C, 16'hBEEF, 1'b0, rc, rd, h, rf);
        tests++; if ({cs_at[1], we_at[1], oe_at[1]} !== 3'b110) begin fails++; $display("FAIL write_strobes: got %b required 110", {cs_at[1], we_at[1], oe_at[1]}); end
        tests++; if ({addr_at[1], wdata_at[1]} !== {14'h11C, 16'hBEEF}) begin fails++; $display("FAIL write_bus: got %h/%h required 011C/BEEF", addr_at[1], wdata_at[1]); end
        tests++; if (rc !== 2) begin fails++; $display("FAIL write_latency: got %0d required 2", rc); end
        tests++; if ({rd, h} !== {16'hBEEF, 1'b0}) begin fails++; $display("FAIL write_resp: got %h hit=%b required BEEF hit=0", rd, h); end
        tests++; if (ram_mem[14'h11C] !== 16'hBEEF) begin fails++; $display("FAIL write_through: got %h required BEEF", ram_mem[14'h11C]); end
        tests++; if (miss_count !== 2'd2) begin fails++; $display("FAIL miss_count2: got %0d required 2", miss_count); end
        issue(1'b0, 14'h11C, 16'h0, 1'b0, rc, rd, h, rf);
        tests++; if ({rc == 1, rd, h} !== {1'b1, 16'hBEEF, 1'b1}) begin fails++; $display("FAIL read_after_write: got cyc=%0d %h hit=%b required cyc=1 BEEF hit=1", rc, rd, h); end
        tests++; if (hit_count !== 2'd2) begin fails++; $display("FAIL hit_count2: got %0d required 2", hit_count); end
    endtask

    task automatic test_conflict();
        int rc; logic [DW-1:0] rd; logic h, rf;
        apply_reset();
        issue(1'b0, 14'h120, 16'h0, 1'b0, rc, rd, h, rf);
        issue(1'b0, 14'h130, 16'h0, 1'b0, rc, rd, h, rf);
        tests++; if ({rc == 3, rd, h} !== {1'b1, 16'h1301, 1'b0}) begin fails++; $display("FAIL conflict_130: got cyc=%0d %h hit=%b required cyc=3 1301 hit=0", rc, rd, h); end
        tests++; if (miss_count !== 2'd2) begin fails++; $display("FAIL conflict_count2: got %0d required 2", miss_count); end
        issue(1'b0, 14'h120, 16'h0, 1'b0, rc, rd, h, rf);
        tests++; if ({rc == 3, rd, h} !== {1'b1, 16'h0001, 1'b0}) begin fails++; $display("FAIL conflict_120: got cyc=%0d %h hit=%b required cyc=3 0001 hit=0", rc, rd, h); end
        tests++; if ({hit_count, miss_count} !== {2'd0, 2'd3}) begin fails++; $display("FAIL conflict_counts: got %0d/%0d required 0/3", hit_count, miss_count); end
    endtask

    task automatic test_flush();
        int rc; logic [DW-1:0] rd; logic h, rf;
        apply_reset();
        issue(1'b1, 14'h11C, 16'hBEEF, 1'b0, rc, rd, h, rf);
        issue(1'b0, 14'h11C, 16'h0, 1'b1, rc, rd, h, rf);
        tests++; if (rf !== 1'b0) begin fails++; $display("FAIL flush_ready: got %b required 0", rf); end
        tests++; if ({rc == 3, h} !== 2'b10) begin fails++; $display("FAIL flush_miss: got cyc=%0d hit=%b required cyc=3 hit=0", rc, h); end
        tests++; if ({cs_at[1], addr_at[1]} !== {1'b1, 14'h11C}) begin fails++; $display("FAIL flush_fill: got cs=%b addr=%h required cs=1 addr=011C", cs_at[1], addr_at[1]); end
        tests++; if (rd !== 16'hBEEF) begin fails++; $display("FAIL flush_rdata: got %h required BEEF", rd); end
        tests++; if ({hit_count, miss_count} !== {2'd0, 2'd2}) begin fails++; $display("FAIL flush_counts: got %0d/%0d required 0/2", hit_count, miss_count); end
    endtask

    task automatic test_saturate();
        int rc; logic [DW-1:0] rd; logic h, rf;
        apply_reset();
        issue(1'b0, 14'h120, 16'h0, 1'b0, rc, rd, h, rf);
        for (int i = 0; i < 5; i++) issue(1'b0, 14'h120, 16'h0, 1'b0, rc, rd, h, rf);
        tests++; if (h !== 1'b1) begin fails++; $display("FAIL sat_last_hit: got %b required 1", h); end
        tests++; if ({hit_count, miss_count} !== {2'd3, 2'd1}) begin fails++; $display("FAIL sat_counts: got %0d/%0d required 3/1", hit_count, miss_count); end
    endtask

    task automatic test_reset_mid();
        int rc; logic [DW-1:0] rd; logic h, rf; logic seen;
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 14'h150;
        @(negedge clk);
        tests++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL mid_accept: got %b required 1", bus.req_ready); end
        @(posedge clk); #1 bus.req_valid = 1'b0;
        @(negedge clk);
        tests++; if (bus.ram_cs !== 1'b1) begin fails++; $display("FAIL mid_fill_cs: got %b required 1", bus.ram_cs); end
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        tests++; if (bus.req_ready !== 1'b0) begin fails++; $display("FAIL mid_ready: got %b required 0", bus.req_ready); end
        @(posedge clk); #1;
        @(negedge clk);
        tests++; if ({bus.resp_valid, bus.ram_cs, bus.ram_we, bus.ram_oe} !== 4'b0000) begin fails++; $display("FAIL mid_quiet: got %b required 0000", {bus.resp_valid, bus.ram_cs, bus.ram_we, bus.ram_oe}); end
        tests++; if ({hit_count, miss_count} !== 4'h0) begin fails++; $display("FAIL mid_counts: got %0d/%0d required 0/0", hit_count, miss_count); end
        @(posedge clk); #1 rst = 1'b0;
        seen = 1'b0;
        repeat (4) begin @(negedge clk); if (bus.resp_valid) seen = 1'b1; end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL mid_no_resp: got %b required 0", seen); end
        issue(1'b0, 14'h150, 16'h0, 1'b0, rc, rd, h, rf);
        tests++; if ({rc == 3, rd, h} !== {1'b1, 16'h5A5A, 1'b0}) begin fails++; $display("FAIL mid_reread: got cyc=%0d %h hit=%b required cyc=3 5A5A hit=0", rc, rd, h); end
        tests++; if (miss_count !== 2'd1) begin fails++; $display("FAIL mid_miss_count: got %0d required 1", miss_count); end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.ram_rdata = '0;
        for (int i = 0; i < (1 << AW); i++) ram_mem[i] = '0;
        ram_mem[14'h120] = 16'h0001;
        ram_mem[14'h130] = 16'h1301;
        ram_mem[14'h150] = 16'h5A5A;
        test_reset();
        test_read_miss_hit();
        test_write();
        test_conflict();
        test_flush();
        test_saturate();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
